// File: rtl/hit_chime_audio.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : hit_chime_audio
//  Description : Four-note square-wave chime on the mono audio jack,
//                triggered (and retriggered) by a game hit strobe.
//  Revision    : 1.0  initial release
// ============================================================================
module hit_chime_audio #(
  parameter int unsigned NOTE_CYCLES = 2500000,
  parameter int unsigned HP0         = 11944,
  parameter int unsigned HP1         = 9480,
  parameter int unsigned HP2         = 7972,
  parameter int unsigned HP3         = 5972
) (
  input  logic clk,
  input  logic reset,
  input  logic hit,
  output logic chSel,
  output logic audioOut,
  output logic audioEn
);

  localparam logic [0:0]  c_IDLE     = 1'b0;
  localparam logic [0:0]  c_PLAY     = 1'b1;
  localparam logic [1:0]  c_LAST_IDX = 2'd3;
  localparam logic [31:0] c_DUR_LAST = NOTE_CYCLES - 32'd1;

  logic [0:0]  r_state;
  logic [1:0]  r_note_idx;
  logic [31:0] r_dur_cnt;
  logic [31:0] r_half_cnt;
  logic        r_audio_out;
  logic        r_audio_en;

  logic [31:0] w_hp;
  logic [31:0] w_hp_last;
  logic        w_rest;
  logic        w_note_end;

  // Note table: half-period of the current note, zero marks a rest
  always_comb begin
    w_hp = 32'(HP0);
    case (r_note_idx)
      2'd0:    w_hp = 32'(HP0);
      2'd1:    w_hp = 32'(HP1);
      2'd2:    w_hp = 32'(HP2);
      2'd3:    w_hp = 32'(HP3);
      default: w_hp = 32'(HP0);
    endcase
  end

  assign w_hp_last  = w_hp - 32'd1;
  assign w_rest     = (w_hp == 32'd0);
  assign w_note_end = (r_dur_cnt == c_DUR_LAST);

  // Chime sequencer: hit restarts, duration counter steps notes, half counter toggles the tone
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= c_IDLE;
      r_note_idx  <= 2'd0;
      r_dur_cnt   <= 32'd0;
      r_half_cnt  <= 32'd0;
      r_audio_out <= 1'b0;
      r_audio_en  <= 1'b0;
    end else if (hit) begin
      // A hit always (re)starts from note 0 and beats any note-end update
      r_state     <= c_PLAY;
      r_note_idx  <= 2'd0;
      r_dur_cnt   <= 32'd0;
      r_half_cnt  <= 32'd0;
      r_audio_out <= 1'b0;
      r_audio_en  <= 1'b1;
    end else if (r_state == c_PLAY) begin
      if (w_note_end) begin
        r_dur_cnt   <= 32'd0;
        r_half_cnt  <= 32'd0;
        r_audio_out <= 1'b0;
        if (r_note_idx == c_LAST_IDX) begin
          r_state    <= c_IDLE;
          r_note_idx <= 2'd0;
          r_audio_en <= 1'b0;
        end else begin
          r_note_idx <= r_note_idx + 2'd1;
        end
      end else begin
        r_dur_cnt <= r_dur_cnt + 32'd1;
        if (w_rest) begin
          r_half_cnt  <= 32'd0;
          r_audio_out <= 1'b0;
        end else if (r_half_cnt == w_hp_last) begin
          r_half_cnt  <= 32'd0;
          r_audio_out <= ~r_audio_out;
        end else begin
          r_half_cnt <= r_half_cnt + 32'd1;
        end
      end
    end
  end

  assign chSel    = 1'b0;
  assign audioOut = r_audio_out;
  assign audioEn  = r_audio_en;

endmodule
`default_nettype wire

// File: tb/tb_hit_chime_audio.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_hit_chime_audio
//  Description : Self-checking bench for hit_chime_audio against a timeline
//                model (cycles since last hit -> note and phase).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_hit_chime_audio;

  localparam int NC = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic hit = 1'b0;
  logic chSel;
  logic audioOut;
  logic audioEn;

  int errors = 0;
  int checks = 0;

  // Reference model state: is a chime running, and how many edges since its hit
  bit m_active = 1'b0;
  int m_d = 0;
  int tbl[4] = '{4, 3, 2, 0};

  hit_chime_audio #(
    .NOTE_CYCLES(NC),
    .HP0(4),
    .HP1(3),
    .HP2(2),
    .HP3(0)
  ) dut (
    .clk(clk),
    .reset(reset),
    .hit(hit),
    .chSel(chSel),
    .audioOut(audioOut),
    .audioEn(audioEn)
  );

  always #5 clk = ~clk;

  function automatic logic m_en();
    return m_active;
  endfunction

  // Square wave phase: each note starts low, flips every HP cycles; rest stays low
  function automatic logic m_out();
    int n, p, hp;
    if (!m_active) return 1'b0;
    n  = m_d / NC;
    p  = m_d % NC;
    hp = tbl[n];
    if (hp == 0) return 1'b0;
    return logic'((p / hp) % 2);
  endfunction

  // Drive inputs for one edge and advance the model; outputs settle #1 later
  task automatic step(input logic h, input logic r);
    hit   = h;
    reset = r;
    @(posedge clk);
    if (r) begin
      m_active = 1'b0;
      m_d      = 0;
    end else if (h) begin
      m_active = 1'b1;
      m_d      = 0;
    end else if (m_active) begin
      m_d = m_d + 1;
      if (m_d >= 4 * NC) begin
        m_active = 1'b0;
        m_d      = 0;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1);
      checks++;
      if ({chSel, audioEn, audioOut} !== 3'b000) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d got chSel/en/out=%b%b%b want 000", i, chSel, audioEn, audioOut);
      end
    end
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0);
      checks++;
      if ({chSel, audioEn, audioOut} !== 3'b000) begin
        errors++;
        $display("FAIL reset_release cyc=%0d got chSel/en/out=%b%b%b want 000", i, chSel, audioEn, audioOut);
      end
    end
  endtask

  task automatic test_single_chime();
    step(1'b1, 1'b0);
    for (int i = 0; i < 70; i++) begin
      checks++;
      if ({chSel, audioEn, audioOut} !== {1'b0, m_en(), m_out()}) begin
        errors++;
        $display("FAIL single_chime d=%0d got chSel/en/out=%b%b%b want 0%b%b", i, chSel, audioEn, audioOut, m_en(), m_out());
      end
      step(1'b0, 1'b0);
    end
  endtask

  task automatic test_retrigger();
    step(1'b1, 1'b0);
    for (int i = 1; i < 20; i++) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    checks++;
    if ({audioEn, audioOut} !== 2'b10) begin
      errors++;
      $display("FAIL retrigger_restart got en/out=%b%b want 10", audioEn, audioOut);
    end
    for (int i = 0; i < 70; i++) begin
      step(1'b0, 1'b0);
      checks++;
      if ({chSel, audioEn, audioOut} !== {1'b0, m_en(), m_out()}) begin
        errors++;
        $display("FAIL retrigger cyc=%0d got chSel/en/out=%b%b%b want 0%b%b", i, chSel, audioEn, audioOut, m_en(), m_out());
      end
    end
  endtask

  task automatic test_held_hit();
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0);
      checks++;
      if ({audioEn, audioOut} !== 2'b10) begin
        errors++;
        $display("FAIL held_hit cyc=%0d got en/out=%b%b want 10", i, audioEn, audioOut);
      end
    end
    for (int i = 0; i < 70; i++) begin
      step(1'b0, 1'b0);
      checks++;
      if ({chSel, audioEn, audioOut} !== {1'b0, m_en(), m_out()}) begin
        errors++;
        $display("FAIL held_followup cyc=%0d got chSel/en/out=%b%b%b want 0%b%b", i, chSel, audioEn, audioOut, m_en(), m_out());
      end
    end
  endtask

  task automatic test_back_to_back();
    step(1'b1, 1'b0);
    for (int i = 1; i < 4 * NC; i++) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    checks++;
    if ({audioEn, audioOut} !== 2'b10) begin
      errors++;
      $display("FAIL back_to_back_edge got en/out=%b%b want 10", audioEn, audioOut);
    end
    for (int i = 0; i < 70; i++) begin
      step(1'b0, 1'b0);
      checks++;
      if ({chSel, audioEn, audioOut} !== {1'b0, m_en(), m_out()}) begin
        errors++;
        $display("FAIL back_to_back cyc=%0d got chSel/en/out=%b%b%b want 0%b%b", i, chSel, audioEn, audioOut, m_en(), m_out());
      end
    end
  endtask

  task automatic test_reset_mid();
    step(1'b1, 1'b0);
    for (int i = 1; i < 30; i++) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    checks++;
    if ({chSel, audioEn, audioOut} !== 3'b000) begin
      errors++;
      $display("FAIL reset_mid got chSel/en/out=%b%b%b want 000", chSel, audioEn, audioOut);
    end
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0);
      checks++;
      if ({audioEn, audioOut} !== 2'b00) begin
        errors++;
        $display("FAIL reset_mid_idle cyc=%0d got en/out=%b%b want 00", i, audioEn, audioOut);
      end
    end
    step(1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      checks++;
      if ({chSel, audioEn, audioOut} !== {1'b0, m_en(), m_out()}) begin
        errors++;
        $display("FAIL reset_mid_rehit d=%0d got chSel/en/out=%b%b%b want 0%b%b", i, chSel, audioEn, audioOut, m_en(), m_out());
      end
      step(1'b0, 1'b0);
    end
  endtask

  task automatic test_random();
    logic h, r;
    for (int i = 0; i < 3000; i++) begin
      h = ($urandom_range(0, 39) == 0);
      r = ($urandom_range(0, 299) == 0);
      step(h, r);
      checks++;
      if ({chSel, audioEn, audioOut} !== {1'b0, m_en(), m_out()}) begin
        errors++;
        $display("FAIL random cyc=%0d hit=%b rst=%b got chSel/en/out=%b%b%b want 0%b%b", i, h, r, chSel, audioEn, audioOut, m_en(), m_out());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_chime();
    test_retrigger();
    test_held_hit();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
